// File: rtl/rr_arb4_ctrl.sv
// rr_arb4_ctrl: four-requester round-robin arbiter for one shared datapath port.
// A 2-bit rotating pointer sets the scan start. The owner keeps the grant until
// it pulses done or drops its request.
// Optional feature macro: RR_ARB4_TIMEOUT_EN. When defined, a hold counter
// force-releases a grant after MAX_HOLD cycles and pulses timeout.
// Debug outputs dbg_state and dbg_ptr expose the FSM state and the priority
// pointer to checkers.
//
// Handshake: req is a level held by a client until it is served. gnt is
// registered and one-hot, and rises on the edge after req is seen in IDLE.
// Only done[gnt_id] is honoured. Every grant is followed by at least one IDLE
// cycle before the next grant.
module rr_arb4_ctrl #(
  parameter int MAX_HOLD = 8,
  parameter int HOLD_W   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic [3:0] done,
  output logic [3:0] gnt,
  output logic [1:0] gnt_id,
  output logic       busy,
  output logic       timeout,
  output logic [0:0] dbg_state,
  output logic [1:0] dbg_ptr
);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_GRANT = 1'b1;

  // Reject configurations where the hold counter cannot reach MAX_HOLD-1.
  if (MAX_HOLD < 2 || (2 ** HOLD_W) <= MAX_HOLD) begin : g_bad_cfg
    $error("rr_arb4_ctrl: MAX_HOLD must be >=2 and below 2**HOLD_W");
  end

  logic [0:0] state_q, state_d;
  logic [1:0] ptr_q, ptr_d;
  logic [3:0] gnt_q, gnt_d;
  logic [1:0] gnt_id_q, gnt_id_d;
  logic       busy_q, busy_d;

  logic       win_found;
  logic [1:0] win_id;
  logic [1:0] scan_idx;
  logic       release_c;
  logic       expire_c;

  // Scan requests starting at the pointer; the first set bit wins.
  always_comb begin
    win_found = 1'b0;
    win_id    = ptr_q;
    scan_idx  = ptr_q;
    for (int i = 0; i < 4; i++) begin
      scan_idx = ptr_q + 2'(i);
      if (!win_found && req[scan_idx]) begin
        win_found = 1'b1;
        win_id    = scan_idx;
      end
    end
  end

  // The owner gives up the resource by pulsing done or withdrawing its request.
  assign release_c = (state_q == S_GRANT) && (done[gnt_id_q] || !req[gnt_id_q]);

`ifdef RR_ARB4_TIMEOUT_EN
  logic [HOLD_W-1:0] hold_q, hold_d;

  assign expire_c = (state_q == S_GRANT) && (hold_q == HOLD_W'(MAX_HOLD - 1));

  // Hold counter: cleared on every new grant, advances while the grant is kept.
  always_comb begin
    hold_d = hold_q;
    if (state_q == S_IDLE) begin
      hold_d = '0;
    end else if (!release_c && !expire_c) begin
      hold_d = hold_q + {{(HOLD_W-1){1'b0}}, 1'b1};
    end
  end

  // Hold counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_q <= '0;
    end else begin
      hold_q <= hold_d;
    end
  end
`else
  assign expire_c = 1'b0;
`endif

  // Arbiter FSM next state: grant a winner from IDLE and release from GRANT.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    gnt_d    = gnt_q;
    gnt_id_d = gnt_id_q;
    busy_d   = busy_q;
    case (state_q)
      S_IDLE: begin
        if (win_found) begin
          state_d  = S_GRANT;
          gnt_d    = 4'b0001 << win_id;
          gnt_id_d = win_id;
          busy_d   = 1'b1;
        end
      end
      S_GRANT: begin
        if (release_c || expire_c) begin
          state_d = S_IDLE;
          gnt_d   = 4'b0000;
          busy_d  = 1'b0;
          ptr_d   = gnt_id_q + 2'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
        gnt_d   = 4'b0000;
        busy_d  = 1'b0;
      end
    endcase
  end

  // Arbiter FSM registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      ptr_q    <= 2'd0;
      gnt_q    <= 4'b0000;
      gnt_id_q <= 2'd0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      gnt_q    <= gnt_d;
      gnt_id_q <= gnt_id_d;
      busy_q   <= busy_d;
    end
  end

  // A forced release pulses timeout in the last held cycle, unless the owner
  // released in that same cycle.
  assign timeout   = !rst && expire_c && !release_c;

  assign gnt       = gnt_q;
  assign gnt_id    = gnt_id_q;
  assign busy      = busy_q;
  assign dbg_state = state_q;
  assign dbg_ptr   = ptr_q;

endmodule

// File: tb/tb_rr_arb4_ctrl.sv
// tb_rr_arb4_ctrl: scoreboard bench for rr_arb4_ctrl.
// A behavioural model predicts the registered outputs for each driven cycle.
// Each prediction is pushed to exp_q when the stimulus is applied, and popped
// and compared after the clock edge.
module tb_rr_arb4_ctrl;

  localparam int MAX_HOLD = 8;
  localparam int HOLD_W   = 4;
  localparam int W        = 10;  // {state, ptr[1:0], busy, gnt_id[1:0], gnt[3:0]}

  // ---------------- clock / reset block ----------------
  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic [3:0] done;
  logic [3:0] gnt;
  logic [1:0] gnt_id;
  logic       busy;
  logic       timeout;
  logic [0:0] dbg_state;
  logic [1:0] dbg_ptr;

  always #5 clk = ~clk;

  rr_arb4_ctrl #(.MAX_HOLD(MAX_HOLD), .HOLD_W(HOLD_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .done      (done),
    .gnt       (gnt),
    .gnt_id    (gnt_id),
    .busy      (busy),
    .timeout   (timeout),
    .dbg_state (dbg_state),
    .dbg_ptr   (dbg_ptr)
  );

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;
  logic last_to;

  // Reference model state.
  logic       m_state = 1'b0;
  logic [1:0] m_ptr   = 2'd0;
  logic [1:0] m_gid   = 2'd0;
  int         m_hold  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- driver ----------------
  // One clock cycle: apply inputs, check the combinational timeout, predict the
  // registered outputs, then clock and compare.
  task automatic step(input logic [3:0] r, input logic [3:0] d, input logic rs);
    logic [W-1:0] e;
    logic         exp_to;
    logic         rel;
    logic         expire;
    logic         found;
    logic [1:0]   idx;
    req  = r;
    done = d;
    rst  = rs;
    #1;
    exp_to = 1'b0;
    if (rs) begin
      m_state = 1'b0;
      m_ptr   = 2'd0;
      m_gid   = 2'd0;
      m_hold  = 0;
    end else if (m_state == 1'b0) begin
      found = 1'b0;
      for (int i = 0; i < 4; i++) begin
        idx = m_ptr + 2'(i);
        if (!found && r[idx]) begin
          found   = 1'b1;
          m_gid   = idx;
          m_state = 1'b1;
          m_hold  = 0;
        end
      end
    end else begin
      rel = d[m_gid] || !r[m_gid];
`ifdef RR_ARB4_TIMEOUT_EN
      expire = (m_hold == MAX_HOLD - 1);
`else
      expire = 1'b0;
`endif
      if (rel || expire) begin
        exp_to  = expire && !rel;
        m_state = 1'b0;
        m_ptr   = m_gid + 2'd1;
      end else begin
        m_hold++;
      end
    end
    last_to = timeout;
    check("timeout", {31'd0, timeout}, {31'd0, exp_to});
    e = {m_state, m_ptr, m_state, m_gid, (m_state ? (4'b0001 << m_gid) : 4'b0000)};
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check("gnt", {28'd0, gnt}, {28'd0, e[3:0]});
    check("busy", {31'd0, busy}, {31'd0, e[6]});
    check("state", {31'd0, dbg_state}, {31'd0, e[9]});
    check("ptr", {30'd0, dbg_ptr}, {30'd0, e[8:7]});
    if (e[6]) check("gnt_id", {30'd0, gnt_id}, {30'd0, e[5:4]});
    check("onehot", ($countones(gnt) <= 1) ? 32'd1 : 32'd0, 32'd1);
  endtask

  // ---------------- stimulus ----------------
  logic [3:0] order[5];
  int gnt_hi_cnt;
  int to_cnt;

  initial begin
    order[0] = 4'b0001; order[1] = 4'b0010; order[2] = 4'b0100;
    order[3] = 4'b1000; order[4] = 4'b0001;
    rst = 1'b1; req = 4'b0000; done = 4'b0000; last_to = 1'b0;
    @(posedge clk);
    #1;

    // T1: reset with all requests active, then first grant to client 0.
    step(4'b1111, 4'b0000, 1'b1);
    step(4'b1111, 4'b0000, 1'b1);
    check("t1_gnt_rst", {28'd0, gnt}, 32'd0);
    step(4'b1111, 4'b0000, 1'b0);
    check("t1_first_gnt", {28'd0, gnt}, 32'd1);
    check("t1_first_id", {30'd0, gnt_id}, 32'd0);

    // T2: rotation 0,1,2,3,0 with an idle cycle between grants.
    for (int k = 1; k < 5; k++) begin
      step(4'b1111, 4'b0001 << gnt_id, 1'b0);
      check("t2_gap", {28'd0, gnt}, 32'd0);
      step(4'b1111, 4'b0000, 1'b0);
      check("t2_order", {28'd0, gnt}, {28'd0, order[k]});
    end
    step(4'b1111, 4'b0001, 1'b0);

    // T3: pointer at 3 wraps to client 0, then client 1.
    step(4'b0000, 4'b0000, 1'b1);
    step(4'b0100, 4'b0000, 1'b0);
    step(4'b0100, 4'b0100, 1'b0);
    check("t3_ptr3", {30'd0, dbg_ptr}, 32'd3);
    step(4'b0011, 4'b0000, 1'b0);
    check("t3_wrap", {28'd0, gnt}, 32'd1);
    step(4'b0011, 4'b0001, 1'b0);
    step(4'b0011, 4'b0000, 1'b0);
    check("t3_next", {28'd0, gnt}, 32'd2);

    // T4: client 2 never releases.
    step(4'b0000, 4'b0000, 1'b1);
    step(4'b0100, 4'b0000, 1'b0);
    gnt_hi_cnt = 0;
    to_cnt = 0;
    for (int k = 0; k < MAX_HOLD; k++) begin
      if (gnt == 4'b0100) gnt_hi_cnt++;
      step(4'b0100, 4'b0000, 1'b0);
      if (last_to) to_cnt++;
    end
    check("t4_hold_cycles", gnt_hi_cnt, MAX_HOLD);
`ifdef RR_ARB4_TIMEOUT_EN
    check("t4_timeouts", to_cnt, 1);
    check("t4_released", {28'd0, gnt}, 32'd0);
    check("t4_ptr", {30'd0, dbg_ptr}, 32'd3);
`else
    check("t4_timeouts", to_cnt, 0);
    check("t4_still_held", {28'd0, gnt}, 32'd4);
`endif

    // T5: done on the final hold cycle is a normal release; non-owner done is ignored.
    step(4'b0000, 4'b0000, 1'b1);
    step(4'b0100, 4'b0000, 1'b0);
    for (int k = 0; k < MAX_HOLD - 1; k++) step(4'b0100, 4'b0000, 1'b0);
    step(4'b0100, 4'b0100, 1'b0);
    check("t5_no_timeout", {31'd0, last_to}, 32'd0);
    check("t5_released", {28'd0, gnt}, 32'd0);
    step(4'b0000, 4'b0000, 1'b1);
    step(4'b0001, 4'b0000, 1'b0);
    step(4'b0001, 4'b1000, 1'b0);
    check("t5_nonowner", {28'd0, gnt}, 32'd1);

    // T6: withdrawal releases; reset mid-grant clears grant and pointer.
    step(4'b0000, 4'b0000, 1'b0);
    check("t6_withdraw", {28'd0, gnt}, 32'd0);
    step(4'b0110, 4'b0000, 1'b0);
    step(4'b0110, 4'b0000, 1'b0);
    step(4'b0110, 4'b0000, 1'b1);
    check("t6_rst_gnt", {28'd0, gnt}, 32'd0);
    check("t6_rst_ptr", {30'd0, dbg_ptr}, 32'd0);

    // Random traffic against the model.
    for (int k = 0; k < 400; k++) begin
      step(4'($urandom_range(0, 15)),
           ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000,
           ($urandom_range(0, 49) == 0));
    end

    check("queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
